tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter W, default 4, meaning bits per channel slot (W >= 2).
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port d, input, 1 bit: serial TDM data, one bit per clk.
REQ-005 SHALL have port fs, input, 1 bit: frame sync, high coincident with bit 0 of slot 0.
REQ-006 SHALL have ports y0, y1, y2, y3, each output, W bits: last accepted frame, channels 0..3.
REQ-007 SHALL have port vld, output, 1 bit: one-cycle pulse when y0..y3 update.
REQ-008 SHALL have port err, output, 1 bit: one-cycle pulse on framing or parity error.
REQ-009 SHALL have port s, output, 2 bits: slot index of the bit currently being sampled.

Function
REQ-010 SHALL implement states HUNT and RECV.
REQ-011 In HUNT, SHALL ignore d while fs=0; on fs=1, SHALL sample d as slot 0 bit 0 and enter RECV.
REQ-012 Bits within a slot SHALL arrive LSB first; slots SHALL arrive in order 0,1,2,3.
REQ-013 SHALL keep a bit counter 0..W-1 and a slot counter 0..3; the bit counter wraps each slot and the slot counter wraps each frame.
REQ-014 Each completed slot SHALL be held in a staging register; y0..y3 SHALL NOT change until the whole frame is accepted.
REQ-015 On acceptance, SHALL load y0..y3 together and assert vld for exactly one cycle, in the cycle after the last frame bit is sampled.
REQ-016 At a frame boundary with fs=1, SHALL stay in RECV with no gap, giving back-to-back frames every 4W cycles (4W+1 with parity).
REQ-017 At a frame boundary with fs=0, SHALL pulse err, discard nothing already accepted, and enter HUNT.
REQ-018 On fs=1 mid-frame (not at the boundary bit), SHALL pulse err, discard the partial frame, and restart at slot 0 bit 0, using the current d as that bit.
REQ-019 y0..y3 SHALL hold their values indefinitely between acceptances.
REQ-020 s SHALL read 0 in HUNT.
REQ-021 When vld and err would coincide, err SHALL take priority and vld SHALL stay low.

Reset
REQ-022 While rst=1: state HUNT, counters 0, y0..y3 = 0, vld = 0, err = 0, s = 0, staging registers cleared.
REQ-023 A reset asserted mid-frame SHALL abort that frame with no vld and no err.

Configuration
REQ-024 With macro TDM_DEMUX_PARITY_EN defined, each frame SHALL carry one extra bit after slot 3: even parity over all 4W data bits.
REQ-025 With the macro defined, a good parity bit SHALL accept the frame; a bad parity bit SHALL pulse err, leave y0..y3 unchanged, and continue per REQ-016/017.
REQ-026 Without the macro, the frame SHALL be exactly 4W bits and no parity logic SHALL be present.

Structure
REQ-027 Package tdm_demux_pkg SHALL hold the state typedef (HUNT, RECV), the constant N_CH = 4, and the slot-index width.
REQ-028 Sub-module tdm_slot_shift SHALL be a W-bit LSB-first shift register with clear and parallel output, instantiated once per staging slot.

Verification (W=4)
REQ-029 Frame with fs, slots 0xA, 0x5, 0x3, 0xC -> vld high one cycle after the 16th bit; y0=A, y1=5, y2=3, y3=C; err=0.
REQ-030 Three back-to-back frames with fs each boundary -> vld every 16 cycles, never err, s cycles 0..3 every 4 clk.
REQ-031 fs re-asserted at frame bit 7 -> err pulse that cycle, no vld, y unchanged; next full frame from that bit accepted 16 cycles later.
REQ-032 fs low at a boundary after a good frame -> err pulse, state HUNT, no vld until the next fs-led frame completes.
REQ-033 rst pulsed at frame bit 10 -> all outputs 0 asynchronously, no vld, HUNT on release.
REQ-034 TDM_DEMUX_PARITY_EN defined, data 0xA, 0x5, 0x3, 0xC with parity bit 1 (bad) -> err pulse, no vld, y unchanged; parity bit 0 -> vld, y updated.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM demultiplexer.
package tdm_demux_pkg;

    // Receiver states: searching for frame sync, or collecting a frame.
    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Channels (slots) per frame and the width of a slot index.
    localparam int N_CH   = 4;
    localparam int SLOT_W = 2;

endpackage

// File: rtl/tdm_slot_shift.sv
// W-bit LSB-first shift register for one staging slot.
// New bits enter at the MSB, so after W shifts the first bit sits at bit 0.
// A clear together with a shift leaves only the incoming bit, which lets a
// frame restart load its first bit in the same cycle as the discard.
module tdm_slot_shift
    import tdm_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    // Shift register with clear; clear wins over history, not over the new bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= en ? {din, {(W-1){1'b0}}} : '0;
        end else if (en) begin
            q <= {din, q[W-1:1]};
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: four W-bit slots per frame, LSB first, frame sync
// fs coincident with slot 0 bit 0. Completed frames are published on y0..y3
// with a one-cycle vld pulse; framing/parity problems give a one-cycle err
// pulse. vld and err are registered and appear in the cycle after the bit
// that caused them.
// Optional feature: define TDM_DEMUX_PARITY_EN to append one even-parity bit
// after slot 3 (covering all 4W data bits); bad parity rejects the frame.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d,
    input  logic              fs,
    output logic [W-1:0]      y0,
    output logic [W-1:0]      y1,
    output logic [W-1:0]      y2,
    output logic [W-1:0]      y3,
    output logic              vld,
    output logic              err,
    output logic [SLOT_W-1:0] s
);

    localparam int                  BIT_W     = $clog2(W);
    localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(W - 1);
    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(N_CH - 1);

    state_t              state_reg, state_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic [SLOT_W-1:0]   slot_reg, slot_next;
`ifdef TDM_DEMUX_PARITY_EN
    logic                par_reg, par_next;
    logic                par_bad;
`endif

    logic                boundary;
    logic                restart;
    logic                take;
    logic [SLOT_W-1:0]   take_slot;
    logic                stage_clr;
    logic                accept;
    logic                frame_err;

    logic [N_CH-1:0]     stage_en;
    logic [W-1:0]        stage_q  [N_CH];
    logic [W-1:0]        load_val [N_CH];
    logic [W-1:0]        y_reg    [N_CH];
    logic                vld_reg;
    logic                err_reg;

    // Staging slots; load_val is what each slot holds once this cycle's bit
    // lands, so the final data bit can be published without an extra cycle.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
            assign stage_en[gi] = take && (take_slot == SLOT_W'(gi));

            tdm_slot_shift #(.W(W)) u_shift (
                .clk (clk),
                .rst (rst),
                .clr (stage_clr),
                .en  (stage_en[gi]),
                .din (d),
                .q   (stage_q[gi])
            );

            assign load_val[gi] = stage_en[gi] ? {d, stage_q[gi][W-1:1]} : stage_q[gi];
        end
    endgenerate

    // The position right after a completed frame; slot 3 during the parity
    // bit keeps this from matching anywhere else.
    assign boundary = (bit_reg == '0) && (slot_reg == '0);

`ifdef TDM_DEMUX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero.
    always_comb begin
        par_bad = d;
        for (int i = 0; i < N_CH; i++) begin
            par_bad = par_bad ^ (^stage_q[i]);
        end
    end
`endif

    // Next-state, counter and control decode.
    always_comb begin
        state_next = state_reg;
        bit_next   = bit_reg;
        slot_next  = slot_reg;
`ifdef TDM_DEMUX_PARITY_EN
        par_next   = par_reg;
`endif
        restart    = 1'b0;
        take       = 1'b0;
        take_slot  = slot_reg;
        stage_clr  = 1'b0;
        accept     = 1'b0;
        frame_err  = 1'b0;

        unique case (state_reg)
            HUNT: begin
                if (fs) begin
                    restart = 1'b1;
                end
            end
            RECV: begin
                if (boundary) begin
                    if (fs) begin
                        restart = 1'b1;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = HUNT;
                        bit_next   = '0;
                        slot_next  = '0;
                    end
                end else if (fs) begin
                    // Sync in the middle of a frame: drop it and resync here.
                    frame_err = 1'b1;
                    restart   = 1'b1;
                end
`ifdef TDM_DEMUX_PARITY_EN
                else if (par_reg) begin
                    par_next  = 1'b0;
                    bit_next  = '0;
                    slot_next = '0;
                    if (par_bad) begin
                        frame_err = 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                end
`endif
                else begin
                    take = 1'b1;
                    if (bit_reg == BIT_LAST) begin
                        bit_next = '0;
                        if (slot_reg == SLOT_LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                            // Slot index stays at 3 while the parity bit arrives.
                            par_next = 1'b1;
`else
                            slot_next = '0;
                            accept    = 1'b1;
`endif
                        end else begin
                            slot_next = slot_reg + SLOT_W'(1);
                        end
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase

        // Current d becomes slot 0 bit 0 of a fresh frame.
        if (restart) begin
            state_next = RECV;
            take       = 1'b1;
            take_slot  = '0;
            stage_clr  = 1'b1;
            bit_next   = BIT_W'(1);
            slot_next  = '0;
`ifdef TDM_DEMUX_PARITY_EN
            par_next   = 1'b0;
`endif
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HUNT;
            bit_reg   <= '0;
            slot_reg  <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            bit_reg   <= bit_next;
            slot_reg  <= slot_next;
`ifdef TDM_DEMUX_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    // Output registers: publish a whole frame at once; err beats vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                y_reg[i] <= '0;
            end
            vld_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            if (accept && !frame_err) begin
                for (int i = 0; i < N_CH; i++) begin
                    y_reg[i] <= load_val[i];
                end
            end
            vld_reg <= accept && !frame_err;
            err_reg <= frame_err;
        end
    end

    assign y0  = y_reg[0];
    assign y1  = y_reg[1];
    assign y2  = y_reg[2];
    assign y3  = y_reg[3];
    assign vld = vld_reg;
    assign err = err_reg;
    assign s   = (state_reg == RECV) ? slot_reg : '0;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux (W=4). Honours TDM_DEMUX_PARITY_EN if defined.
module tb_tdm_demux;

    localparam int W  = 4;
    localparam int NB = 4 * W;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = NB + PAR;

    logic         clk = 1'b0;
    logic         rst;
    logic         d;
    logic         fs;
    logic [W-1:0] y0, y1, y2, y3;
    logic         vld;
    logic         err;
    logic [1:0]   s;

    tdm_demux #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .fs  (fs),
        .y0  (y0),
        .y1  (y1),
        .y2  (y2),
        .y3  (y3),
        .vld (vld),
        .err (err),
        .s   (s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame as a flat bit index.
    bit           m_hunt;
    int           m_pos;
    bit           m_bits [FL];
    logic [W-1:0] m_y [4];
    bit           m_vld;
    bit           m_err;

    typedef struct {
        logic [NB-1:0] data;
        bit            par_bad;
        bit            exp_vld;
        bit            exp_err;
        logic [NB-1:0] exp_y;   // {y3, y2, y1, y0}
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1;
        m_pos  = 0;
        m_vld  = 1'b0;
        m_err  = 1'b0;
        for (int c = 0; c < 4; c++) m_y[c] = '0;
    endtask

    task automatic model_step(input bit bd, input bit bfs);
        int ones;
        m_vld = 1'b0;
        m_err = 1'b0;
        if (m_hunt) begin
            if (bfs) begin
                m_bits[0] = bd;
                m_pos     = 1;
                m_hunt    = 1'b0;
            end
        end else if (m_pos == 0) begin
            if (bfs) begin
                m_bits[0] = bd;
                m_pos     = 1;
            end else begin
                m_err  = 1'b1;
                m_hunt = 1'b1;
            end
        end else if (bfs) begin
            m_err     = 1'b1;
            m_bits[0] = bd;
            m_pos     = 1;
        end else begin
            m_bits[m_pos] = bd;
            m_pos++;
            if (m_pos == FL) begin
                m_pos = 0;
                ones  = 0;
                for (int k = 0; k < FL; k++) ones += int'(m_bits[k]);
                if (PAR == 0 || (ones % 2) == 0) begin
                    for (int c = 0; c < 4; c++)
                        for (int b = 0; b < W; b++)
                            m_y[c][b] = m_bits[c*W + b];
                    m_vld = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    function automatic int exp_s();
        if (m_hunt) return 0;
        return (m_pos / W > 3) ? 3 : m_pos / W;
    endfunction

    // One clock of stimulus with full model comparison.
    task automatic step(input bit bd, input bit bfs);
        d  = bd;
        fs = bfs;
        chk("s", 32'(s), 32'(exp_s()));
        @(posedge clk);
        model_step(bd, bfs);
        #1;
        chk("vld", 32'(vld), 32'(m_vld));
        chk("err", 32'(err), 32'(m_err));
        chk("y0", 32'(y0), 32'(m_y[0]));
        chk("y1", 32'(y1), 32'(m_y[1]));
        chk("y2", 32'(y2), 32'(m_y[2]));
        chk("y3", 32'(y3), 32'(m_y[3]));
    endtask

    task automatic send_frame(input logic [NB-1:0] data, input bit par_bad);
        bit pb;
        for (int k = 0; k < NB; k++) step(data[k], k == 0);
        if (PAR != 0) begin
            pb = (^data) ^ par_bad;
            step(pb, 1'b0);
        end
    endtask

    initial begin
        vec_t          v;
        logic [NB-1:0] saved_y;
        logic [NB-1:0] nd;
        int            p;

        // Reset state
        rst = 1'b1;
        d   = 1'b0;
        fs  = 1'b0;
        #12;
        chk("rst_y", 32'({y3, y2, y1, y0}), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        $display("reset: y=%h vld=%0d err=%0d s=%0d", {y3, y2, y1, y0}, vld, err, s);

        // Idle cycles in HUNT with fs low: d ignored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

        // Vector table: back-to-back frames
        tbl.push_back('{16'hC35A, 1'b0, 1'b1, 1'b0, 16'hC35A});
        tbl.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000});
        tbl.push_back('{16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hFFFF});
        tbl.push_back('{16'h1234, 1'b0, 1'b1, 1'b0, 16'h1234});
`ifdef TDM_DEMUX_PARITY_EN
        tbl.push_back('{16'hC35A, 1'b1, 1'b0, 1'b1, 16'h1234});
        tbl.push_back('{16'hC35A, 1'b0, 1'b1, 1'b0, 16'hC35A});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            send_frame(v.data, v.par_bad);
            chk("tbl_vld", 32'(vld), 32'(v.exp_vld));
            chk("tbl_err", 32'(err), 32'(v.exp_err));
            chk("tbl_y", 32'({y3, y2, y1, y0}), 32'(v.exp_y));
            $display("vec %0d: data=%h par_bad=%0d vld=%0d err=%0d y=%h",
                     i, v.data, v.par_bad, vld, err, {y3, y2, y1, y0});
        end

        // fs low at the boundary after a good frame: err, back to HUNT
        saved_y = {y3, y2, y1, y0};
        step(1'b1, 1'b0);
        chk("bnd_err", 32'(err), 32'd1);
        chk("bnd_vld", 32'(vld), 32'd0);
        chk("bnd_y", 32'({y3, y2, y1, y0}), 32'(saved_y));
        for (int i = 0; i < 6; i++) step(1'(i), 1'b0);
        chk("hunt_s", 32'(s), 32'd0);
        send_frame(16'h5AA5, 1'b0);
        chk("hunt_recover_vld", 32'(vld), 32'd1);
        chk("hunt_recover_y", 32'({y3, y2, y1, y0}), 32'h5AA5);
        $display("seq boundary-fs-low: err seen, recovered y=%h", {y3, y2, y1, y0});

        // fs re-asserted at frame bit 7: partial frame dropped, resync there
        nd      = 16'h2B4E;
        saved_y = {y3, y2, y1, y0};
        for (int k = 0; k < 7; k++) step(1'(k % 2), k == 0);
        step(nd[0], 1'b1);
        chk("mid_err", 32'(err), 32'd1);
        chk("mid_vld", 32'(vld), 32'd0);
        chk("mid_y", 32'({y3, y2, y1, y0}), 32'(saved_y));
        for (int k = 1; k < NB; k++) begin
            step(nd[k], 1'b0);
            if (k < NB - 1 || PAR != 0) chk("mid_novld", 32'(vld), 32'd0);
        end
        if (PAR != 0) step(^nd, 1'b0);
        chk("mid_resync_vld", 32'(vld), 32'd1);
        chk("mid_resync_y", 32'({y3, y2, y1, y0}), 32'(nd));
        $display("seq mid-frame-fs: resynced frame y=%h", {y3, y2, y1, y0});

        // Reset pulsed at frame bit 10: outputs clear asynchronously
        for (int k = 0; k < 10; k++) step(1'b1, k == 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_y", 32'({y3, y2, y1, y0}), 32'd0);
        chk("arst_vld", 32'(vld), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_s", 32'(s), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        send_frame(16'h8E71, 1'b0);
        chk("arst_recover_y", 32'({y3, y2, y1, y0}), 32'h8E71);
        $display("seq mid-frame-reset: cleared then y=%h", {y3, y2, y1, y0});

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            p = (m_hunt || m_pos == 0) ? 80 : 3;
            step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < p);
        end
        $display("random: 3000 cycles done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
